// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants, FSM state type and counter-width helper for cfg_frame_loader
package cfg_pkg;
  localparam logic [7:0] CFG_HDR  = 8'hA5;
  localparam logic [7:0] CRC_POLY = 8'h07;
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, COMMIT, WAIT, READBACK} state_t;
  function automatic int clog2(input int v);
    for (int w = 0; w < 31; w++) if ((1 << w) >= v) return w;
    return 31;
  endfunction
endpackage

// File: rtl/cfg_frame_loader_if.sv
// cfg_frame_loader_if: serial config bus
//   master: drives s_in/frame/read, observes s_out/cfg/cfg_valid/crc_err/hdr_err/busy
//   slave : the loader side
interface cfg_frame_loader_if #(parameter int N = 96) ();
  logic         s_in;
  logic         frame;
  logic         read;
  logic         s_out;
  logic [N-1:0] cfg;
  logic         cfg_valid;
  logic         crc_err;
  logic         hdr_err;
  logic         busy;
  modport master (output s_in, frame, read, input s_out, cfg, cfg_valid, crc_err, hdr_err, busy);
  modport slave  (input s_in, frame, read, output s_out, cfg, cfg_valid, crc_err, hdr_err, busy);
endinterface

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 (poly 0x07, init 0, MSB first)
//   clk/reset: clock, async active-low reset; clr: sync clear; en: absorb d; crc: current remainder
module crc8_serial
  import cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       d,
  output logic [7:0] crc
);
  logic [7:0] crc_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) crc_q <= '0;
    else if (clr) crc_q <= '0;
    else if (en) crc_q <= {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ d) ? CRC_POLY : 8'h00);
  assign crc = crc_q;
endmodule

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: framed, CRC-checked serial config loader with atomic commit and readback
//   clk  : serial bit clock
//   reset: async active-low reset
//   bus  : slave side of cfg_frame_loader_if (s_in, frame, read in; s_out, cfg, cfg_valid, crc_err, hdr_err, busy out)
module cfg_frame_loader
  import cfg_pkg::*;
#(
  parameter int           N         = 96,
  parameter logic [N-1:0] CFG_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  cfg_frame_loader_if.slave   bus
);
  localparam int            CW        = clog2(N + 1);
  localparam logic [CW-1:0] LAST_PAY  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(7);
  localparam logic [CW-1:0] RB_DONE   = CW'(N);
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    sh_q;
  logic [N-1:0]  stage_q, cfg_q, rb_q;
  logic          valid_q, crc_err_q, hdr_err_q, s_out_q;
  logic [7:0]    crc;
  logic [7:0]    byte_in;
  logic          start;
  // header and CRC fields share one byte shifter; byte_in is the byte completed by this edge
  assign byte_in = {sh_q[6:0], bus.s_in};
  // a rising frame in READBACK is treated exactly like IDLE with frame=1
  assign start   = bus.frame && (state_q == IDLE || state_q == READBACK);
  crc8_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (state_q == PAYLOAD && bus.frame),
    .d     (bus.s_in),
    .crc   (crc)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      stage_q   <= '0;
      cfg_q     <= CFG_RESET;
      rb_q      <= '0;
      valid_q   <= 1'b0;
      crc_err_q <= 1'b0;
      hdr_err_q <= 1'b0;
      s_out_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start) begin
        state_q   <= HDR;
        cnt_q     <= CW'(1);
        sh_q      <= {7'b0, bus.s_in};
        crc_err_q <= 1'b0;
        hdr_err_q <= 1'b0;
        s_out_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE:
            if (bus.read) begin
              rb_q    <= cfg_q;
              cnt_q   <= '0;
              state_q <= READBACK;
            end
          HDR, PAYLOAD, CRC:
            if (!bus.frame) state_q <= IDLE;
            else begin
              sh_q  <= byte_in;
              cnt_q <= cnt_q + CW'(1);
              if (state_q == PAYLOAD) stage_q <= {stage_q[N-2:0], bus.s_in};
              if (state_q == PAYLOAD && cnt_q == LAST_PAY) begin
                state_q <= CRC;
                cnt_q   <= '0;
              end else if (state_q != PAYLOAD && cnt_q == LAST_BYTE) begin
                cnt_q <= '0;
                if (state_q == HDR) begin
                  state_q   <= (byte_in == CFG_HDR) ? PAYLOAD : WAIT;
                  hdr_err_q <= byte_in != CFG_HDR;
                end else begin
                  state_q   <= (byte_in == crc) ? COMMIT : WAIT;
                  crc_err_q <= byte_in != crc;
                end
              end
            end
          COMMIT: begin
            cfg_q   <= stage_q;
            valid_q <= 1'b1;
            state_q <= WAIT;
          end
          WAIT:
            if (!bus.frame) state_q <= IDLE;
          READBACK:
            if (cnt_q == RB_DONE) begin
              state_q <= IDLE;
              s_out_q <= 1'b0;
            end else begin
              s_out_q <= rb_q[N-1];
              rb_q    <= {rb_q[N-2:0], 1'b0};
              cnt_q   <= cnt_q + CW'(1);
            end
          default: state_q <= IDLE;
        endcase
      end
    end
  assign bus.cfg       = cfg_q;
  assign bus.cfg_valid = valid_q;
  assign bus.crc_err   = crc_err_q;
  assign bus.hdr_err   = hdr_err_q;
  assign bus.s_out     = s_out_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb_cfg_frame_loader: directed + randomized checks of cfg_frame_loader (N=96 and N=8 instances)
module tb_cfg_frame_loader;
  logic clk = 1'b0, rst_n = 1'b0, s_in = 1'b0, f96 = 1'b0, f8 = 1'b0, rd = 1'b0;
  int n_assert = 0, n_fail = 0, p96 = 0, p8 = 0, c96 = 0, c8 = 0;
  logic [95:0] exp96 = '0;
  logic [7:0]  exp8  = 8'h5A;
  always #5 clk = ~clk;
  cfg_frame_loader_if #(.N(96)) b96 ();
  cfg_frame_loader_if #(.N(8))  b8 ();
  assign b96.s_in  = s_in;
  assign b96.frame = f96;
  assign b96.read  = rd;
  assign b8.s_in   = s_in;
  assign b8.frame  = f8;
  assign b8.read   = 1'b0;
  cfg_frame_loader #(.N(96)) u96 (.clk(clk), .reset(rst_n), .bus(b96));
  cfg_frame_loader #(.N(8), .CFG_RESET(8'h5A)) u8 (.clk(clk), .reset(rst_n), .bus(b8));
  always @(posedge clk) begin
    if (b96.cfg_valid) p96 <= p96 + 1;
    if (b8.cfg_valid) p8 <= p8 + 1;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // reference CRC: long division of (payload followed by 8 zero bits) by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [95:0] p, input int n);
    logic [8:0] r = '0;
    for (int i = n - 1; i >= -8; i--) begin
      r = {r[7:0], (i >= 0) ? p[i] : 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction
  // drives header/payload/crc MSB first; cut>0 stops after that many bits with frame still high
  task automatic send(input bit sel8, input logic [7:0] hdr, input logic [95:0] pay, input int n, input logic [7:0] crc, input int cut);
    bit q[$];
    for (int i = 7; i >= 0; i--) q.push_back(hdr[i]);
    for (int i = n - 1; i >= 0; i--) q.push_back(pay[i]);
    for (int i = 7; i >= 0; i--) q.push_back(crc[i]);
    if (cut > 0) q = q[0:cut-1];
    foreach (q[i]) begin
      @(negedge clk);
      s_in = q[i];
      if (sel8) f8 = 1'b1; else f96 = 1'b1;
    end
  endtask
  task automatic check_result(input bit sel8, input logic [95:0] pay, input bit hbad, input bit cbad, input string tag);
    bit ok = !hbad && !cbad;
    @(negedge clk);
    chk({tag, ".hdr_err"}, sel8 ? 96'(b8.hdr_err) : 96'(b96.hdr_err), 96'(hbad));
    chk({tag, ".crc_err"}, sel8 ? 96'(b8.crc_err) : 96'(b96.crc_err), 96'(cbad));
    chk({tag, ".valid_k"}, sel8 ? 96'(b8.cfg_valid) : 96'(b96.cfg_valid), 96'(0));
    f96 = 1'b0;
    f8 = 1'b0;
    s_in = 1'b0;
    @(negedge clk);
    if (ok) begin
      if (sel8) begin exp8 = pay[7:0]; c8++; end
      else begin exp96 = pay; c96++; end
    end
    chk({tag, ".valid_k1"}, sel8 ? 96'(b8.cfg_valid) : 96'(b96.cfg_valid), 96'(ok));
    chk({tag, ".cfg"}, sel8 ? 96'(b8.cfg) : b96.cfg, sel8 ? 96'(exp8) : exp96);
    @(negedge clk);
    chk({tag, ".valid_k2"}, sel8 ? 96'(b8.cfg_valid) : 96'(b96.cfg_valid), 96'(0));
    chk({tag, ".busy"}, sel8 ? 96'(b8.busy) : 96'(b96.busy), 96'(0));
  endtask
  initial begin
    logic [95:0] pay, rbval;
    logic [7:0] c;
    bit bad;
    int p0;
    repeat (3) @(negedge clk);
    chk("rst.cfg96", b96.cfg, 96'(0));
    chk("rst.cfg8", 96'(b8.cfg), 96'(8'h5A));
    chk("rst.out96", {b96.busy, b96.cfg_valid, b96.crc_err, b96.hdr_err, b96.s_out}, 96'(0));
    chk("rst.out8", {b8.busy, b8.cfg_valid, b8.crc_err, b8.hdr_err, b8.s_out}, 96'(0));
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'hA5, '0, 96, crc_ref('0, 96), 0);
    check_result(0, '0, 0, 0, "zero96");
    send(1, 8'hA5, 96'h01, 8, crc_ref(96'h01, 8), 0);
    check_result(1, 96'h01, 0, 0, "n8_good");
    send(1, 8'hA5, 96'h01, 8, crc_ref(96'h01, 8) ^ 8'h01, 0);
    check_result(1, 96'h01, 0, 1, "n8_badcrc");
    for (int i = 0; i < 6; i++) begin
      pay = {$urandom, $urandom, $urandom};
      bad = $urandom_range(0, 2) == 0;
      c = crc_ref(pay, 96) ^ (bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      send(0, 8'hA5, pay, 96, c, 0);
      check_result(0, pay, 0, bad, "rand96");
    end
    for (int i = 0; i < 4; i++) begin
      pay = 96'($urandom_range(0, 255));
      bad = $urandom_range(0, 1) == 0;
      c = crc_ref(pay, 8) ^ (bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      send(1, 8'hA5, pay, 8, c, 0);
      check_result(1, pay, 0, bad, "rand8");
    end
    pay = {$urandom, $urandom, $urandom};
    send(0, 8'hA4, pay, 96, crc_ref(pay, 96), 0);
    check_result(0, pay, 1, 0, "badhdr");
    pay = {$urandom, $urandom, $urandom};
    send(0, 8'hA5, pay, 96, crc_ref(pay, 96), 0);
    check_result(0, pay, 0, 0, "after_badhdr");
    p0 = p96;
    pay = {$urandom, $urandom, $urandom};
    send(0, 8'hA5, pay, 96, crc_ref(pay, 96), 48);
    @(negedge clk);
    chk("drop.busy_before", 96'(b96.busy), 96'(1));
    f96 = 1'b0;
    @(negedge clk);
    chk("drop.busy", 96'(b96.busy), 96'(0));
    chk("drop.cfg", b96.cfg, exp96);
    chk("drop.flags", {b96.crc_err, b96.hdr_err}, 96'(0));
    chk("drop.pulses", 96'(p96 - p0), 96'(0));
    pay = {$urandom, $urandom, $urandom};
    send(0, 8'hA5, pay, 96, crc_ref(pay, 96), 0);
    check_result(0, pay, 0, 0, "after_drop");
    rbval = 96'hA5_1122_3344_5566_7788_99AA_3C;
    send(0, 8'hA5, rbval, 96, crc_ref(rbval, 96), 0);
    check_result(0, rbval, 0, 0, "rbval");
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk("rb.first", {b96.busy, b96.s_out}, 96'(2'b10));
    for (int j = 0; j < 96; j++) begin
      @(negedge clk);
      chk("rb.bit", 96'(b96.s_out), 96'(rbval[95-j]));
    end
    @(negedge clk);
    chk("rb.end", {b96.busy, b96.s_out}, 96'(0));
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("rb2.bit", 96'(b96.s_out), 96'(rbval[95-j]));
    end
    pay = {$urandom, $urandom, $urandom};
    send(0, 8'hA5, pay, 96, crc_ref(pay, 96), 0);
    check_result(0, pay, 0, 0, "rb_abort");
    chk("rb_abort.s_out", 96'(b96.s_out), 96'(0));
    pay = {$urandom, $urandom, $urandom};
    send(0, 8'hA5, pay, 96, crc_ref(pay, 96), 28);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp96 = '0;
    exp8 = 8'h5A;
    chk("rstp.cfg96", b96.cfg, exp96);
    chk("rstp.out96", {b96.busy, b96.cfg_valid, b96.crc_err, b96.hdr_err, b96.s_out}, 96'(0));
    chk("rstp.cfg8", 96'(b8.cfg), 96'(exp8));
    f96 = 1'b0;
    s_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pay = {$urandom, $urandom, $urandom};
    send(0, 8'hA5, pay, 96, crc_ref(pay, 96), 0);
    check_result(0, pay, 0, 0, "after_rst");
    pay = 96'($urandom_range(0, 255));
    send(1, 8'hA5, pay, 8, crc_ref(pay, 8), 0);
    check_result(1, pay, 0, 0, "after_rst8");
    @(negedge clk);
    chk("pulses96", 96'(p96), 96'(c96));
    chk("pulses8", 96'(p8), 96'(c8));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
